mem_port_arbiter: RTL and testbench

- Shares the processor's single 16-bit memory port between two requesters: instruction fetch (IF) and the load/store unit (LS).
- Sits between the 3-stage pipeline and memory. Serializes accesses onto one request/acknowledge memory interface.
- LS has priority. A starvation counter guarantees IF forward progress.

---
 rtl/mem_arb_pkg.sv | 19 +
 rtl/arb_starve_ctr.sv | 27 ++
 rtl/mem_port_arbiter.sv | 138 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the memory port arbiter.
// Owner and state encodings are also used by the bench.
package mem_arb_pkg;

    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    typedef enum logic {
        G_IF,
        G_LS
    } owner_t;

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating count of LS grants taken while a fetch was waiting.
// at_max forces the next grant to the fetch side.
module arb_starve_ctr #(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic at_max
);

    localparam int CW = $clog2(STARVE_MAX + 1);

    logic [CW-1:0] cnt;

    assign at_max = (cnt == CW'(STARVE_MAX));

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (inc && !at_max) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serializes IF and LS accesses onto a single req/ack memory port.
// LS wins arbitration unless the starvation counter forces an IF grant.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_valid,
    output logic [DATA_W-1:0] if_data,
    input  logic              ls_rd_req,
    input  logic              ls_wr_req,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    output logic              ls_ready,
    output logic [DATA_W-1:0] ls_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              err,
    output state_t            state_dbg
);

    // Handshake: mem_req rises the cycle after a grant and holds with all
    // mem_* fields stable until the cycle mem_ack=1 is sampled; done pulses
    // (if_valid / ls_ready) are one cycle wide, the cycle after that ack.

    state_t state;
    owner_t owner;

    logic ls_pend;
    logic starve_at_max;
    logic grant_ls;
    logic grant_if;
    logic starve_inc;
    logic starve_clr;

    assign state_dbg = state;
    assign ls_pend   = ls_rd_req | ls_wr_req;

    always_comb begin
        grant_ls   = 1'b0;
        grant_if   = 1'b0;
        starve_inc = 1'b0;
        starve_clr = 1'b0;
        if (state == IDLE) begin
            grant_ls   = ls_pend && !starve_at_max;
            grant_if   = !grant_ls && if_req;
            starve_inc = grant_ls && if_req;
            starve_clr = grant_if || !if_req;
        end
    end

    arb_starve_ctr #(
        .STARVE_MAX(STARVE_MAX)
    ) u_starve (
        .clk    (clk),
        .rst    (rst),
        .inc    (starve_inc),
        .clr    (starve_clr),
        .at_max (starve_at_max)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            owner     <= G_IF;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_valid  <= 1'b0;
            if_data   <= '0;
            ls_ready  <= 1'b0;
            ls_rdata  <= '0;
            err       <= 1'b0;
        end else begin
            if_valid <= 1'b0;
            ls_ready <= 1'b0;
            if (mem_ack && state != ACCESS) begin
                err <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (grant_ls) begin
                        owner     <= G_LS;
                        mem_req   <= 1'b1;
                        mem_we    <= ls_wr_req;
                        mem_addr  <= ls_addr;
                        mem_wdata <= ls_wr_req ? ls_wdata : '0;
                        // Conflicting load+store resolves as a store.
                        if (ls_rd_req && ls_wr_req) begin
                            err <= 1'b1;
                        end
                        state <= ACCESS;
                    end else if (grant_if) begin
                        owner     <= G_IF;
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b0;
                        mem_addr  <= if_addr;
                        mem_wdata <= '0;
                        state     <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        if (owner == G_IF) begin
                            if_data  <= mem_rdata;
                            if_valid <= 1'b1;
                        end else begin
                            if (!mem_we) begin
                                ls_rdata <= mem_rdata;
                            end
                            ls_ready <= 1'b1;
                        end
                        state <= RESP;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a negedge memory responder
// and a small expected-grant queue for the contention scenario.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [7:0]  if_addr;
    logic        if_valid;
    logic [15:0] if_data;
    logic        ls_rd_req;
    logic        ls_wr_req;
    logic [7:0]  ls_addr;
    logic [15:0] ls_wdata;
    logic        ls_ready;
    logic [15:0] ls_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_ack;
    logic        err;
    state_t      state_dbg;

    int checks   = 0;
    int failures = 0;

    // memory responder state
    logic        auto_mem = 1'b1;
    int          mem_wait = 0;
    logic        resp_ack = 1'b0;
    logic [15:0] resp_rdata = '0;
    logic        man_ack = 1'b0;
    logic [15:0] man_rdata = '0;
    int          wait_cnt = 0;
    bit          mem_init_done = 1'b0;
    logic [15:0] mem_model [256];

    logic [0:0] exp_q [$];

    assign mem_ack   = auto_mem ? resp_ack : man_ack;
    assign mem_rdata = auto_mem ? resp_rdata : man_rdata;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W(8),
        .DATA_W(16),
        .STARVE_MAX(4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_valid  (if_valid),
        .if_data   (if_data),
        .ls_rd_req (ls_rd_req),
        .ls_wr_req (ls_wr_req),
        .ls_addr   (ls_addr),
        .ls_wdata  (ls_wdata),
        .ls_ready  (ls_ready),
        .ls_rdata  (ls_rdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .err       (err),
        .state_dbg (state_dbg)
    );

    // Acks after mem_wait cycles of mem_req; writes commit on the ack.
    always @(negedge clk) begin
        if (!mem_init_done) begin
            for (int i = 0; i < 256; i++) mem_model[i] = 16'h0000;
            mem_model[1]   = 16'hE801;
            mem_model[128] = 16'h0001;
            mem_init_done  = 1'b1;
        end
        if (mem_req && !resp_ack) begin
            if (wait_cnt == mem_wait) begin
                resp_ack   = 1'b1;
                resp_rdata = mem_we ? 16'h0000 : mem_model[mem_addr];
                if (mem_we) mem_model[mem_addr] = mem_wdata;
                wait_cnt   = 0;
            end else begin
                wait_cnt++;
            end
        end else begin
            resp_ack = 1'b0;
            wait_cnt = 0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one request, wait (bounded) for its done pulse, then release it.
    task automatic do_access(input string tag, input bit is_if, input bit rd, input bit wr,
                             input logic [7:0] addr, input logic [15:0] wdata,
                             input bit chk_data, input logic [15:0] exp);
        bit done = 1'b0;
        if (is_if) begin
            if_req  = 1'b1;
            if_addr = addr;
        end else begin
            ls_rd_req = rd;
            ls_wr_req = wr;
            ls_addr   = addr;
            ls_wdata  = wdata;
        end
        for (int i = 0; i < 30 && !done; i++) begin
            step();
            if (is_if ? if_valid : ls_ready) begin
                done = 1'b1;
                if (chk_data) check(tag, is_if ? if_data : ls_rdata, exp);
            end
        end
        if_req    = 1'b0;
        ls_rd_req = 1'b0;
        ls_wr_req = 1'b0;
        if (!done) check({tag, "_timeout"}, 32'd0, 32'd1);
        step();
    endtask

    initial begin
        bit   prev_req;
        int   grants;
        bit   got;
        logic [0:0] exp_owner;

        rst = 1'b1; if_req = 1'b0; if_addr = '0;
        ls_rd_req = 1'b0; ls_wr_req = 1'b0; ls_addr = '0; ls_wdata = '0;
        step();
        step();
        check("rst_state",     32'(state_dbg), 32'(IDLE));
        check("rst_mem_req",   32'(mem_req),   32'd0);
        check("rst_mem_we",    32'(mem_we),    32'd0);
        check("rst_mem_addr",  32'(mem_addr),  32'd0);
        check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        check("rst_if_valid",  32'(if_valid),  32'd0);
        check("rst_if_data",   32'(if_data),   32'd0);
        check("rst_ls_ready",  32'(ls_ready),  32'd0);
        check("rst_ls_rdata",  32'(ls_rdata),  32'd0);
        check("rst_err",       32'(err),       32'd0);
        rst = 1'b0;
        step();

        // single zero-wait fetch
        mem_wait = 0;
        if_req = 1'b1; if_addr = 8'd1;
        step();
        check("fetch_c1_req",   32'(mem_req),   32'd1);
        check("fetch_c1_addr",  32'(mem_addr),  32'd1);
        check("fetch_c1_we",    32'(mem_we),    32'd0);
        check("fetch_c1_state", 32'(state_dbg), 32'(ACCESS));
        step();
        check("fetch_c2_valid", 32'(if_valid),  32'd1);
        check("fetch_c2_data",  32'(if_data),   32'hE801);
        check("fetch_c2_req",   32'(mem_req),   32'd0);
        if_req = 1'b0;
        step();
        check("fetch_c3_valid", 32'(if_valid),  32'd0);
        check("fetch_c3_state", 32'(state_dbg), 32'(IDLE));

        // load with 3 wait states
        mem_wait = 3;
        ls_rd_req = 1'b1; ls_addr = 8'd128;
        for (int c = 1; c <= 4; c++) begin
            step();
            check($sformatf("load_c%0d_req", c), 32'(mem_req), 32'd1);
            check($sformatf("load_c%0d_ready", c), 32'(ls_ready), 32'd0);
        end
        step();
        check("load_c5_ready", 32'(ls_ready), 32'd1);
        check("load_c5_rdata", 32'(ls_rdata), 32'd1);
        check("load_c5_ifv",   32'(if_valid), 32'd0);
        check("load_if_hold",  32'(if_data),  32'hE801);
        ls_rd_req = 1'b0;
        step();
        check("load_c6_ready", 32'(ls_ready), 32'd0);

        // store with one wait state, then read back
        mem_wait = 1;
        ls_wr_req = 1'b1; ls_addr = 8'd130; ls_wdata = 16'd3;
        step();
        check("store_c1_we",    32'(mem_we),    32'd1);
        check("store_c1_addr",  32'(mem_addr),  32'd130);
        check("store_c1_wdata", 32'(mem_wdata), 32'd3);
        step();
        check("store_c2_req",   32'(mem_req),   32'd1);
        check("store_c2_wdata", 32'(mem_wdata), 32'd3);
        step();
        check("store_c3_ready", 32'(ls_ready),  32'd1);
        check("store_rdata_hold", 32'(ls_rdata), 32'd1);
        ls_wr_req = 1'b0;
        step();
        mem_wait = 0;
        do_access("readback_130", 1'b0, 1'b1, 1'b0, 8'd130, 16'd0, 1'b1, 16'd3);

        // contention: both sides held, IF forced after 4 LS grants
        exp_q = {1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        if_req = 1'b1; if_addr = 8'h10;
        ls_rd_req = 1'b1; ls_addr = 8'h80;
        prev_req = 1'b0;
        grants = 0;
        for (int c = 0; c < 60 && grants < 6; c++) begin
            step();
            if (mem_req && !prev_req) begin
                exp_owner = exp_q.pop_front();
                check($sformatf("grant_%0d", grants), 32'(mem_addr != 8'h10), 32'(exp_owner));
                grants++;
            end
            prev_req = mem_req;
            if (if_valid) if_req = 1'b0;
        end
        if (grants < 6) check("grant_timeout", 32'(grants), 32'd6);
        got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            if (ls_ready) got = 1'b1;
            else step();
        end
        ls_rd_req = 1'b0;
        if_req = 1'b0;
        step();
        check("contention_drain", 32'(state_dbg), 32'(IDLE));
        check("err_clean", 32'(err), 32'd0);

        // simultaneous read+write acts as write and flags err
        ls_rd_req = 1'b1; ls_wr_req = 1'b1; ls_addr = 8'd140; ls_wdata = 16'h55AA;
        step();
        check("both_we",    32'(mem_we),    32'd1);
        check("both_wdata", 32'(mem_wdata), 32'h55AA);
        step();
        check("both_ready", 32'(ls_ready),  32'd1);
        check("both_err",   32'(err),       32'd1);
        ls_rd_req = 1'b0; ls_wr_req = 1'b0;
        step();
        do_access("readback_140", 1'b0, 1'b1, 1'b0, 8'd140, 16'd0, 1'b1, 16'h55AA);

        // stray ack while idle
        auto_mem = 1'b0;
        man_ack = 1'b1; man_rdata = 16'hBEEF;
        step();
        man_ack = 1'b0;
        check("stray_state", 32'(state_dbg), 32'(IDLE));
        step();
        check("stray_ifv",   32'(if_valid), 32'd0);
        check("stray_lsr",   32'(ls_ready), 32'd0);
        check("stray_err",   32'(err),      32'd1);

        // reset during ACCESS, then a late ack
        if_req = 1'b1; if_addr = 8'd5;
        step();
        check("rma_access", 32'(state_dbg), 32'(ACCESS));
        rst = 1'b1;
        step();
        check("rma_state", 32'(state_dbg), 32'(IDLE));
        check("rma_req",   32'(mem_req),   32'd0);
        check("rma_err",   32'(err),       32'd0);
        rst = 1'b0; if_req = 1'b0;
        man_ack = 1'b1; man_rdata = 16'hFFFF;
        step();
        man_ack = 1'b0;
        check("late_ifv",   32'(if_valid),  32'd0);
        check("late_state", 32'(state_dbg), 32'(IDLE));
        step();
        check("late_ifv2",  32'(if_valid),  32'd0);
        check("late_data",  32'(if_data),   32'd0);
        check("late_err",   32'(err),       32'd1);
        auto_mem = 1'b1;
        do_access("post_reset_fetch", 1'b1, 1'b0, 1'b0, 8'd1, 16'd0, 1'b1, 16'hE801);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
